// File: rtl/jtcontra_gfx_romrq.sv
// ROM request stage with 2-entry LRU cache. Hit: 1 cycle; miss: 2 cycles + arbiter latency.
// sdram_req is held until sdram_ack. Optional JTCONTRA_ROMRQ_STATS_EN adds hit/miss counters.
module jtcontra_gfx_romrq #(
   parameter int AW = 18,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   input  logic          cs,
   output logic [DW-1:0] data,
   output logic          ok,
   output logic [AW-1:0] sdram_addr,
   output logic          sdram_req,
   input  logic          sdram_ack,
   input  logic          sdram_dst,
   input  logic [DW-1:0] sdram_din
`ifdef JTCONTRA_ROMRQ_STATS_EN
   ,
   output logic [15:0]   hit_cnt,
   output logic [15:0]   miss_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        state;
   logic [AW-1:0] tag  [2];
   logic [DW-1:0] cdat [2];
   logic [1:0]    valid;
   logic          lru;
   logic [AW-1:0] last_addr;
   logic          last_valid;

   logic hit0, hit1, hit, same, idle_hit, start_req, fill;

   assign hit0 = valid[0] && (tag[0] == addr);
   assign hit1 = valid[1] && (tag[1] == addr);
   assign hit  = hit0 || hit1;
   // last_valid guards the post-reset case where last_addr==0 is not real data
   assign same      = last_valid && (addr == last_addr);
   assign idle_hit  = (state == IDLE) && cs && hit;
   assign start_req = (state == IDLE) && cs && !hit && !same;
   assign fill      = ((state == WAIT) && sdram_dst) ||
                      ((state == REQ) && sdram_ack && sdram_dst);

   assign ok = cs && last_valid && (addr == last_addr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         valid      <= 2'b00;
         lru        <= 1'b0;
         data       <= '0;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         last_addr  <= '0;
         last_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (idle_hit) begin
                  data       <= hit1 ? cdat[1] : cdat[0];
                  last_addr  <= addr;
                  last_valid <= 1'b1;
                  lru        <= !hit1;
               end else if (start_req) begin
                  sdram_addr <= addr;
                  sdram_req  <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  state     <= sdram_dst ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (sdram_dst) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (fill) begin
            tag[lru]   <= sdram_addr;
            cdat[lru]  <= sdram_din;
            valid[lru] <= 1'b1;
            data       <= sdram_din;
            last_addr  <= sdram_addr;
            last_valid <= 1'b1;
            lru        <= !lru;
         end
      end
   end

`ifdef JTCONTRA_ROMRQ_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (idle_hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
         if (start_req && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_jtcontra_gfx_romrq.sv
// Bench for jtcontra_gfx_romrq: scripted arbiter handshakes, expected data via a scoreboard queue.
module tb_jtcontra_gfx_romrq;
   localparam int AW = 18;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          cs = 1'b0;
   logic [DW-1:0] data;
   logic          ok;
   logic [AW-1:0] sdram_addr;
   logic          sdram_req;
   logic          sdram_ack = 1'b0;
   logic          sdram_dst = 1'b0;
   logic [DW-1:0] sdram_din = '0;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_d;

   jtcontra_gfx_romrq #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .cs(cs), .data(data), .ok(ok),
      .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
      .sdram_dst(sdram_dst), .sdram_din(sdram_din)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pop_exp();
      if (exp_q.size() > 0) exp_d = exp_q.pop_front();
      else exp_d = 'x;
   endtask

   // Waits for the miss request of a, acks it, returns a after gap idle cycles
   task automatic do_fill(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
      addr = a; cs = 1'b1;
      for (int i = 0; i < 8 && sdram_req !== 1'b1; i++) tick();
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== a) begin
         errors++;
         $display("FAIL fill_req: req=%b addr=%h, want req=1 addr=%h", sdram_req, sdram_addr, a);
      end
      sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
      checks++;
      if (sdram_req !== 1'b0 || ok !== 1'b0) begin
         errors++;
         $display("FAIL fill_wait: req=%b ok=%b, want 0 0", sdram_req, ok);
      end
      repeat (gap) tick();
      sdram_dst = 1'b1; sdram_din = d; exp_q.push_back(d);
      tick();
      sdram_dst = 1'b0; sdram_din = '0;
      pop_exp();
      checks++;
      if (ok !== 1'b1 || data !== exp_d) begin
         errors++;
         $display("FAIL fill_data: ok=%b data=%h, want ok=1 data=%h", ok, data, exp_d);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cs = 1'b0; addr = '0;
      tick(); tick();
      checks++;
      if (data !== '0 || ok !== 1'b0 || sdram_req !== 1'b0 || sdram_addr !== '0) begin
         errors++;
         $display("FAIL reset_state: data=%h ok=%b req=%b saddr=%h, want all 0", data, ok, sdram_req, sdram_addr);
      end
      rst_n = 1'b1; cs = 1'b1; addr = 18'h00100;
      tick();
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== 18'h00100 || ok !== 1'b0) begin
         errors++;
         $display("FAIL first_req: req=%b saddr=%h ok=%b, want 1 00100 0", sdram_req, sdram_addr, ok);
      end
   endtask

   task automatic test_miss_fill();
      sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
      checks++;
      if (sdram_req !== 1'b0 || ok !== 1'b0) begin
         errors++;
         $display("FAIL ack_drop: req=%b ok=%b, want 0 0", sdram_req, ok);
      end
      tick(); tick();
      sdram_dst = 1'b1; sdram_din = 16'hA5C3; exp_q.push_back(16'hA5C3);
      tick();
      sdram_dst = 1'b0; sdram_din = '0;
      pop_exp();
      checks++;
      if (ok !== 1'b1 || data !== exp_d) begin
         errors++;
         $display("FAIL miss_data: ok=%b data=%h, want 1 %h", ok, data, exp_d);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (sdram_req !== 1'b0 || ok !== 1'b1 || data !== 16'hA5C3) begin
            errors++;
            $display("FAIL miss_hold: req=%b ok=%b data=%h, want 0 1 a5c3", sdram_req, ok, data);
         end
      end
   endtask

   task automatic test_hit();
      do_fill(18'h00200, 16'h5A01, 1);
      addr = 18'h00100; #1;
      checks++;
      if (ok !== 1'b0) begin
         errors++;
         $display("FAIL hit_ok_fall: ok=%b, want 0", ok);
      end
      exp_q.push_back(16'hA5C3);
      tick();
      pop_exp();
      checks++;
      if (ok !== 1'b1 || data !== exp_d || sdram_req !== 1'b0) begin
         errors++;
         $display("FAIL hit_data: ok=%b data=%h req=%b, want 1 %h 0", ok, data, sdram_req, exp_d);
      end
      do_fill(18'h00300, 16'h0C0C, 0);
      addr = 18'h00200;
      tick();
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== 18'h00200) begin
         errors++;
         $display("FAIL lru_evict: req=%b saddr=%h, want 1 00200", sdram_req, sdram_addr);
      end
      do_fill(18'h00200, 16'h5A02, 0);
   endtask

   task automatic test_addr_change_wait();
      addr = 18'h00100;
      tick();
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== 18'h00100) begin
         errors++;
         $display("FAIL chg_req: req=%b saddr=%h, want 1 00100", sdram_req, sdram_addr);
      end
      sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
      addr = 18'h00101; #1;
      tick();
      sdram_dst = 1'b1; sdram_din = 16'hBEEF;
      tick();
      sdram_dst = 1'b0; sdram_din = '0;
      checks++;
      if (ok !== 1'b0 || sdram_req !== 1'b0 || data !== 16'hBEEF) begin
         errors++;
         $display("FAIL chg_fill: ok=%b req=%b data=%h, want 0 0 beef", ok, sdram_req, data);
      end
      tick();
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== 18'h00101) begin
         errors++;
         $display("FAIL chg_newreq: req=%b saddr=%h, want 1 00101", sdram_req, sdram_addr);
      end
   endtask

   task automatic test_ack_dst_same();
      sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_din = 16'h1234;
      exp_q.push_back(16'h1234);
      tick();
      sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_din = '0;
      pop_exp();
      checks++;
      if (ok !== 1'b1 || data !== exp_d || sdram_req !== 1'b0) begin
         errors++;
         $display("FAIL same_fill: ok=%b data=%h req=%b, want 1 %h 0", ok, data, sdram_req, exp_d);
      end
      // an IDLE-only hit on the address filled during the earlier WAIT
      addr = 18'h00100; exp_q.push_back(16'hBEEF);
      tick();
      pop_exp();
      checks++;
      if (ok !== 1'b1 || data !== exp_d || sdram_req !== 1'b0) begin
         errors++;
         $display("FAIL same_idle: ok=%b data=%h req=%b, want 1 %h 0", ok, data, sdram_req, exp_d);
      end
   endtask

   task automatic test_reset_mid_fetch();
      addr = 18'h00300;
      tick();
      checks++;
      if (sdram_req !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_req: req=%b, want 1", sdram_req);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (sdram_req !== 1'b0 || ok !== 1'b0 || data !== '0) begin
         errors++;
         $display("FAIL rstmid_drop: req=%b ok=%b data=%h, want 0 0 0", sdram_req, ok, data);
      end
      sdram_dst = 1'b1; sdram_din = 16'hDEAD;
      tick();
      sdram_dst = 1'b0; sdram_din = '0;
      addr = 18'h00100; rst_n = 1'b1;
      tick();
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== 18'h00100 || ok !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_empty: req=%b saddr=%h ok=%b, want 1 00100 0", sdram_req, sdram_addr, ok);
      end
      do_fill(18'h00100, 16'h7777, 0);
   endtask

   initial begin
      tick();
      test_reset();
      test_miss_fill();
      test_hit();
      test_addr_change_wait();
      test_ack_dst_same();
      test_reset_mid_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jtcontra_gfx_romrq.md
Name: jtcontra_gfx_romrq

Overview:
- ROM request stage between one video graphics channel and the SDRAM controller; one instance per channel (gfx1, gfx2).
- Takes the channel's 18-bit ROM address and chip select, and returns 16-bit data with an ok flag.
- Holds a 2-entry fully associative cache with LRU replacement, so repeated tile/object row fetches do not go to SDRAM.
- Misses go through a request/ack/data-strobe handshake with the SDRAM arbiter.

Parameters:
- AW, 18: address width, both sides.
- DW, 16: data width, both sides.

Ports:
- clk  input  1  system clock (48 MHz); the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- addr  input  AW  ROM address from the graphics channel.
- cs  input  1  ROM chip select from the graphics channel.
- data  output  DW  ROM data to the graphics channel.
- ok  output  1  data is valid for the current addr.
- sdram_addr  output  AW  address sent to the SDRAM arbiter.
- sdram_req  output  1  request to the arbiter; held until acknowledged.
- sdram_ack  input  1  one-cycle pulse: request accepted.
- sdram_dst  input  1  one-cycle pulse: sdram_din is valid.
- sdram_din  input  DW  data returned by SDRAM.

Behaviour:
- Reset (rst_n=0 sampled at posedge clk):
  - Both cache valid bits cleared, LRU=0, FSM to IDLE.
  - data=0, ok=0, sdram_req=0, sdram_addr=0.
  - Also applies mid-fetch: sdram_req drops on the next edge. A later sdram_dst is ignored because state is IDLE.
- Cache entries: tag[AW], data[DW], valid. LRU bit points at the entry to replace next. Every hit or fill marks the used entry as most recently used.
- Registered last_addr/last_valid track the address that produced data.
- ok = cs & last_valid & (addr == last_addr). This is combinational over registered state, so ok falls in the same cycle addr changes.
- IDLE:
  - cs=1 and addr hits a valid entry: next edge loads data from that entry, last_addr=addr, last_valid=1, LRU updated. Hit latency is 1 cycle.
  - cs=1, miss, and addr != last_addr: sdram_addr=addr latched, sdram_req=1, go to REQ.
  - cs=0: no activity; data is held.
- REQ: sdram_req held high, sdram_addr stable.
  - On sdram_ack: sdram_req=0, go to WAIT.
  - If sdram_ack and sdram_dst arrive together: treat as a WAIT completion directly (fill, go to IDLE).
- WAIT: on sdram_dst, in the same edge:
  - write sdram_din into the LRU entry (tag=sdram_addr, valid=1);
  - data=sdram_din, last_addr=sdram_addr, last_valid=1;
  - flip LRU; go to IDLE.
  - Miss latency is 2 cycles plus the arbiter latency.
- addr changes while in REQ/WAIT: the fetch still completes and fills the cache, but ok stays 0 because of the mismatch. The new addr is looked up in IDLE on the next cycle.
- cs falls while in REQ/WAIT: the fetch completes; ok=0 while cs=0.
- An address equal to both tags cannot occur, since a fill only happens on a miss.
- No wrap-around concerns: addresses are compared at full AW width.

Optional Feature:
- Macro: JTCONTRA_ROMRQ_STATS_EN.
- When defined, adds:
  - output hit_cnt[15:0], count of IDLE hits;
  - output miss_cnt[15:0], count of REQ entries;
  - both saturate at 16'hFFFF and are cleared by reset.
- When not defined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then cs=1, addr=18'h00100 → sdram_req=1 and sdram_addr=18'h00100 on the cycle after release; ok=0.
- Miss fill: ack at t, dst at t+3 with sdram_din=16'hA5C3 → data=16'hA5C3 and ok=1 from t+4; a new request is not issued while addr is unchanged.
- Cache hit:
  - fill 18'h00100 then 18'h00200;
  - return to 18'h00100 → ok=1 one cycle later with the original data, sdram_req stays 0;
  - then 18'h00300 → evicts 18'h00200 (LRU);
  - a re-read of 18'h00200 issues sdram_req.
- Address change during WAIT: addr moves 18'h00100→18'h00101 before dst → ok stays 0; the fill lands; sdram_req for 18'h00101 rises 1 cycle after returning to IDLE.
- Simultaneous ack and dst in the same cycle with sdram_din=16'h1234 → data=16'h1234, ok=1 next cycle, FSM in IDLE.
- Reset mid-fetch: rst_n=0 while in REQ → sdram_req=0 next edge; after a dst pulse during reset, ok=0 and the cache is empty (next access misses).
